// File: rtl/fma_result_writer.sv
// fma_result_writer: writeback engine for the 8x8 FMA result matrix.
// Captures the 64 x 24-bit result and streams it into the 64-bit matrix
// memory, either as 24 raw words (full mode) or as 8 saturated row-words
// in the same byte layout the FMA uses for matrix B (sat8 mode).
module fma_result_writer #(
    parameter int ACC_WIDTH  = 24,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_wb,
    input  logic [ADDR_WIDTH-1:0]     addr_base,
    input  logic                      mode,
    input  logic [64*ACC_WIDTH-1:0]   mat_in,
    output logic                      busy,
    output logic                      done_wb,
    output logic                      sat_flag,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [63:0]               mem_din,
    output logic                      mem_we,
    input  logic                      mem_ready
);

    localparam int MAT_BITS = 64 * ACC_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(127);
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(-128);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t                  state, state_d;
    logic [4:0]              cnt, cnt_d;
    logic [4:0]              last_idx;
    logic [MAT_BITS-1:0]     mat_q;
    logic                    mode_q;
    logic                    capture;
    logic                    busy_d, done_d, sat_d, we_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [63:0]             din_d;

    function automatic logic clips(input logic signed [ACC_WIDTH-1:0] x);
        return (x > SAT_HI) || (x < SAT_LO);
    endfunction

    function automatic logic [7:0] sat8(input logic signed [ACC_WIDTH-1:0] x);
        if (x > SAT_HI)
            return 8'h7F;
        else if (x < SAT_LO)
            return 8'h80;
        else
            return x[7:0];
    endfunction

    // Memory word k of the given matrix in the given mode.
    function automatic logic [63:0] word_of(input logic [MAT_BITS-1:0] src,
                                            input logic md,
                                            input logic [4:0] k);
        logic [63:0] w;
        w = '0;
        if (md) begin
            for (int unsigned j = 0; j < 8; j++)
                w[j*8 +: 8] = sat8(src[(32'(k[2:0]) * 8 + j) * ACC_WIDTH +: ACC_WIDTH]);
        end else begin
            w = src[32'(k) * 64 +: 64];
        end
        return w;
    endfunction

    function automatic logic any_clip(input logic [MAT_BITS-1:0] src);
        logic f;
        f = 1'b0;
        for (int unsigned i = 0; i < 64; i++)
            f = f | clips(src[i * ACC_WIDTH +: ACC_WIDTH]);
        return f;
    endfunction

    // Next-state and next-output logic; outputs are registered below so the
    // word for the following cycle is prepared here from the captured matrix.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        capture  = 1'b0;
        busy_d   = busy;
        done_d   = 1'b0;
        sat_d    = sat_flag;
        we_d     = mem_we;
        addr_d   = mem_addr;
        din_d    = mem_din;
        last_idx = mode_q ? 5'd7 : 5'd23;
        case (state)
            IDLE: begin
                busy_d = 1'b0;
                we_d   = 1'b0;
                if (start_wb) begin
                    capture = 1'b1;
                    cnt_d   = 5'd0;
                    state_d = WRITE;
                    busy_d  = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = addr_base;
                    din_d   = word_of(mat_in, mode, 5'd0);
                    sat_d   = mode ? any_clip(mat_in) : 1'b0;
                end
            end
            WRITE: begin
                busy_d = 1'b1;
                if (mem_ready) begin
                    if (cnt == last_idx) begin
                        we_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d  = cnt + 5'd1;
                        addr_d = mem_addr + ADDR_WIDTH'(1);
                        din_d  = word_of(mat_q, mode_q, cnt + 5'd1);
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                we_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, word counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done_wb  <= 1'b0;
            sat_flag <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            busy     <= busy_d;
            done_wb  <= done_d;
            sat_flag <= sat_d;
            mem_we   <= we_d;
            mem_addr <= addr_d;
            mem_din  <= din_d;
        end
    end

    // Operand capture on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_q  <= '0;
            mode_q <= 1'b0;
        end else if (capture) begin
            mat_q  <= mat_in;
            mode_q <= mode;
        end
    end

endmodule

// File: tb/tb_fma_result_writer.sv
// Directed testbench for fma_result_writer.
module tb_fma_result_writer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_wb;
    logic [7:0]    addr_base;
    logic          mode;
    logic [1535:0] mat_in;
    logic          busy, done_wb, sat_flag, mem_we, mem_ready;
    logic [7:0]    mem_addr;
    logic [63:0]   mem_din;

    int tests_run    = 0;
    int tests_failed = 0;

    // Results of the most recent run_capture call.
    int          nw, lat, stall_errs, n_stalls;
    logic        first_sat;
    logic [7:0]  cap_addr [64];
    logic [63:0] cap_din  [64];
    logic [1535:0] exp_mat;

    fma_result_writer #(.ACC_WIDTH(24), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_wb(start_wb), .addr_base(addr_base),
        .mode(mode), .mat_in(mat_in), .busy(busy), .done_wb(done_wb),
        .sat_flag(sat_flag), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_we(mem_we), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic set_elem(input int i, input int j, input int v);
        mat_in[(i*8+j)*24 +: 24] = 24'(v);
    endtask

    task automatic fill_all(input int v);
        for (int i = 0; i < 64; i++) mat_in[i*24 +: 24] = 24'(v);
    endtask

    task automatic set_index_pattern();
        for (int i = 0; i < 64; i++) mat_in[i*24 +: 24] = 24'(i);
        exp_mat = mat_in;
    endtask

    // Starts a run and records every accepted write. Inputs are scrambled
    // after the start edge to show they were captured. Returns at the
    // falling edge where done_wb is seen high (lat = edges from the start
    // edge inclusive), or lat = -1 on timeout.
    task automatic run_capture(input logic [7:0] base, input logic md,
                               input bit use_stall, input int poke_at);
        int edges;
        bit prev_stall;
        logic [7:0] pa;
        logic [63:0] pd;
        nw = 0; lat = -1; stall_errs = 0; n_stalls = 0;
        prev_stall = 0; pa = '0; pd = '0;
        @(negedge clk);
        start_wb = 1'b1; addr_base = base; mode = md; mem_ready = 1'b1;
        @(negedge clk);
        start_wb = 1'b0; edges = 1; first_sat = sat_flag;
        addr_base = ~base; mode = ~md; mat_in = ~mat_in;
        for (int c = 0; c < 300; c++) begin
            if (prev_stall && (mem_addr !== pa || mem_din !== pd)) stall_errs++;
            if (done_wb === 1'b1) begin
                lat = edges;
                break;
            end
            if (use_stall) mem_ready = ((c % 3) == 0);
            if (c == poke_at) begin
                start_wb = 1'b1; addr_base = 8'h55; mode = ~md;
            end else begin
                start_wb = 1'b0;
            end
            if (mem_we === 1'b1 && !mem_ready) n_stalls++;
            if (mem_we === 1'b1 && mem_ready) begin
                if (nw < 64) begin
                    cap_addr[nw] = mem_addr;
                    cap_din[nw]  = mem_din;
                end
                nw++;
            end
            prev_stall = (mem_we === 1'b1) && !mem_ready;
            pa = mem_addr; pd = mem_din;
            @(negedge clk);
            edges++;
        end
        start_wb = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        tests_run++;
        if ({busy, done_wb, sat_flag, mem_we} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, done_wb, sat_flag, mem_we});
        end
        tests_run++;
        if (mem_addr !== 8'h00 || mem_din !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_bus: got addr %h din %h expected 0", mem_addr, mem_din);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got busy %b we %b expected 0 0", busy, mem_we);
        end
    endtask

    task automatic test_sat8_identity();
        fill_all(0);
        for (int i = 0; i < 8; i++) set_elem(i, i, 5);
        run_capture(8'h10, 1'b1, 0, -1);
        tests_run++;
        if (nw !== 8) begin
            tests_failed++;
            $display("FAIL ident_count: got %0d expected 8", nw);
        end
        for (int r = 0; r < 8 && r < nw; r++) begin
            logic [63:0] ew;
            ew = 64'h5 << (8 * r);
            tests_run++;
            if (cap_addr[r] !== 8'(8'h10 + r) || cap_din[r] !== ew) begin
                tests_failed++;
                $display("FAIL ident_word%0d: got %h:%h expected %h:%h", r,
                         cap_addr[r], cap_din[r], 8'(8'h10 + r), ew);
            end
        end
        tests_run++;
        if (lat !== 9) begin
            tests_failed++;
            $display("FAIL ident_latency: got %0d expected 9", lat);
        end
        tests_run++;
        if (sat_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL ident_sat_flag: got %b expected 0", sat_flag);
        end
    endtask

    task automatic test_sat8_clip();
        logic [63:0] ew [8];
        fill_all(58);
        set_elem(0, 0, 300);
        set_elem(0, 1, -200);
        set_elem(3, 5, 127);
        set_elem(7, 7, -128);
        for (int r = 0; r < 8; r++) ew[r] = 64'h3A3A3A3A3A3A3A3A;
        ew[0] = 64'h3A3A3A3A3A3A807F;
        ew[3] = 64'h3A3A7F3A3A3A3A3A;
        ew[7] = 64'h803A3A3A3A3A3A3A;
        run_capture(8'h30, 1'b1, 0, -1);
        tests_run++;
        if (first_sat !== 1'b1) begin
            tests_failed++;
            $display("FAIL clip_sat_early: got %b expected 1", first_sat);
        end
        tests_run++;
        if (nw !== 8) begin
            tests_failed++;
            $display("FAIL clip_count: got %0d expected 8", nw);
        end
        for (int r = 0; r < 8 && r < nw; r++) begin
            tests_run++;
            if (cap_din[r] !== ew[r]) begin
                tests_failed++;
                $display("FAIL clip_word%0d: got %h expected %h", r, cap_din[r], ew[r]);
            end
        end
        tests_run++;
        if (sat_flag !== 1'b1) begin
            tests_failed++;
            $display("FAIL clip_sat_flag: got %b expected 1", sat_flag);
        end
    endtask

    task automatic test_full_wrap();
        set_index_pattern();
        run_capture(8'hF0, 1'b0, 0, -1);
        tests_run++;
        if (nw !== 24) begin
            tests_failed++;
            $display("FAIL full_count: got %0d expected 24", nw);
        end
        for (int k = 0; k < 24 && k < nw; k++) begin
            tests_run++;
            if (cap_addr[k] !== 8'(8'hF0 + k) || cap_din[k] !== exp_mat[k*64 +: 64]) begin
                tests_failed++;
                $display("FAIL full_word%0d: got %h:%h expected %h:%h", k,
                         cap_addr[k], cap_din[k], 8'(8'hF0 + k), exp_mat[k*64 +: 64]);
            end
        end
        if (nw >= 24) begin
            tests_run++;
            if (cap_addr[15] !== 8'hFF || cap_addr[16] !== 8'h00 || cap_addr[23] !== 8'h07) begin
                tests_failed++;
                $display("FAIL full_wrap: got %h %h %h expected ff 00 07",
                         cap_addr[15], cap_addr[16], cap_addr[23]);
            end
            tests_run++;
            if (cap_din[0] !== 64'h0002_0000_0100_0000 || cap_din[23] !== 64'h0000_3F00_003E_0000) begin
                tests_failed++;
                $display("FAIL full_edges: got %h %h expected 0002000001000000 00003f00003e0000",
                         cap_din[0], cap_din[23]);
            end
        end
        tests_run++;
        if (lat !== 25) begin
            tests_failed++;
            $display("FAIL full_latency: got %0d expected 25", lat);
        end
        tests_run++;
        if (sat_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_sat_flag: got %b expected 0", sat_flag);
        end
    endtask

    task automatic test_backpressure();
        fill_all(0);
        for (int i = 0; i < 8; i++) set_elem(i, i, 5);
        run_capture(8'h80, 1'b1, 1, -1);
        tests_run++;
        if (nw !== 8) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d expected 8", nw);
        end
        for (int r = 0; r < 8 && r < nw; r++) begin
            tests_run++;
            if (cap_addr[r] !== 8'(8'h80 + r) || cap_din[r] !== (64'h5 << (8 * r))) begin
                tests_failed++;
                $display("FAIL bp_word%0d: got %h:%h expected %h:%h", r,
                         cap_addr[r], cap_din[r], 8'(8'h80 + r), 64'h5 << (8 * r));
            end
        end
        tests_run++;
        if (stall_errs !== 0 || n_stalls < 1) begin
            tests_failed++;
            $display("FAIL bp_hold: got %0d unstable cycles over %0d stalls expected 0 over >0",
                     stall_errs, n_stalls);
        end
        tests_run++;
        if (lat !== 9 + n_stalls) begin
            tests_failed++;
            $display("FAIL bp_latency: got %0d expected %0d", lat, 9 + n_stalls);
        end
    endtask

    task automatic test_start_while_busy();
        set_index_pattern();
        run_capture(8'h60, 1'b0, 0, 5);
        tests_run++;
        if (nw !== 24 || lat !== 25) begin
            tests_failed++;
            $display("FAIL busy_start_run: got %0d writes latency %0d expected 24 and 25", nw, lat);
        end
        for (int k = 0; k < 24 && k < nw; k += 6) begin
            tests_run++;
            if (cap_addr[k] !== 8'(8'h60 + k) || cap_din[k] !== exp_mat[k*64 +: 64]) begin
                tests_failed++;
                $display("FAIL busy_start_word%0d: got %h:%h expected %h:%h", k,
                         cap_addr[k], cap_din[k], 8'(8'h60 + k), exp_mat[k*64 +: 64]);
            end
        end
        // run_capture returns in the DONE cycle: a start here must be dropped.
        start_wb = 1'b1; addr_base = 8'hA0; mode = 1'b1;
        @(negedge clk);
        start_wb = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done_wb !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_start_ignored: got busy %b done %b expected 0 0", busy, done_wb);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_start_idle: got busy %b we %b expected 0 0", busy, mem_we);
        end
    endtask

    task automatic test_reset_mid_op();
        int late_writes;
        set_index_pattern();
        @(negedge clk);
        start_wb = 1'b1; addr_base = 8'h20; mode = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        start_wb = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (mem_addr !== 8'h23 || mem_we !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pre_addr: got %h we %b expected 23 1", mem_addr, mem_we);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done_wb, sat_flag, mem_we} !== 4'b0 || mem_addr !== 8'h00 || mem_din !== 64'h0) begin
            tests_failed++;
            $display("FAIL rst_async: got flags %b addr %h din %h expected 0",
                     {busy, done_wb, sat_flag, mem_we}, mem_addr, mem_din);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        late_writes = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_we !== 1'b0) late_writes++;
        end
        tests_run++;
        if (late_writes !== 0) begin
            tests_failed++;
            $display("FAIL rst_no_writes: got %0d write cycles expected 0", late_writes);
        end
        set_index_pattern();
        run_capture(8'h40, 1'b0, 0, -1);
        tests_run++;
        if (nw !== 24 || lat !== 25 || cap_addr[0] !== 8'h40 || cap_din[0] !== 64'h0002_0000_0100_0000) begin
            tests_failed++;
            $display("FAIL rst_fresh_run: got %0d writes lat %0d first %h:%h expected 24 25 40:0002000001000000",
                     nw, lat, cap_addr[0], cap_din[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0; start_wb = 1'b0; addr_base = '0; mode = 1'b0;
        mem_ready = 1'b1; mat_in = '0; exp_mat = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_sat8_identity();
        test_sat8_clip();
        test_full_wrap();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
